ins_fetch: RTL and testbench

INS_FETCH -- requirements
Module: ins_fetch

---
 rtl/ins_fetch_if.sv | 32 +++
 rtl/ins_fetch.sv | 85 ++++++++
 tb/tb_ins_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ins_fetch_if.sv
// ins_fetch_if -- fetch-unit bus bundle.
//   Requester side : FetchReq, PCWre, NextPC (fetch control and PC load)
//   Memory side    : MemReq, MemAddr out; MemAck, MemData in
//   IR side        : DateOut, IRWre
//   Status         : CurPC, Busy, Done, Err
// The slave modport belongs to the fetch unit. The master modport belongs to
// whatever drives the unit, such as the core plus the instruction memory.
interface ins_fetch_if;
  logic        FetchReq;
  logic        PCWre;
  logic [31:0] NextPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic [31:0] DateOut;
  logic        IRWre;
  logic [31:0] CurPC;
  logic        Busy;
  logic        Done;
  logic        Err;

  modport slave (
    input  FetchReq, PCWre, NextPC, MemAck, MemData,
    output MemReq, MemAddr, DateOut, IRWre, CurPC, Busy, Done, Err
  );

  modport master (
    output FetchReq, PCWre, NextPC, MemAck, MemData,
    input  MemReq, MemAddr, DateOut, IRWre, CurPC, Busy, Done, Err
  );
endinterface

// File: rtl/ins_fetch.sv
// ins_fetch -- single-outstanding instruction fetch unit.
//   CLK    : clock; all state updates on the rising edge
//   Reset  : asynchronous, active-low
//   bus    : ins_fetch_if.slave (fetch control, memory handshake, IR write, status)
// FSM: IDLE -> MEM (wait for MemAck, bounded by TIMEOUT) -> WRITE (IR write, PC+4) -> IDLE.
// A misaligned fetch, or a memory timeout, produces a one-cycle Err pulse.
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic      CLK,
  input  logic      Reset,
  ins_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, WRITE} state_t;

  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [31:0]   pc, dout;
  logic [CW-1:0] wcnt;
  logic          err_q;
  logic          misal, start, bad_fetch, timeout, got_ack;

  // The fetch address is NextPC when a PC load happens in the same cycle.
  assign misal     = bus.PCWre ? (|bus.NextPC[1:0]) : (|pc[1:0]);
  assign start     = (state == IDLE) && bus.FetchReq && !misal;
  assign bad_fetch = (state == IDLE) && bus.FetchReq && misal;
  assign got_ack   = (state == MEM) && bus.MemAck;
  // An ack in the last allowed cycle wins over the timeout.
  assign timeout   = (state == MEM) && !bus.MemAck && (wcnt == TO_LAST);

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = MEM;
      MEM:     if (got_ack) state_nxt = WRITE;
               else if (timeout) state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.MemReq  = (state == MEM);
    bus.Busy    = (state != IDLE);
    bus.IRWre   = (state == WRITE);
    bus.Done    = (state == WRITE);
    bus.Err     = err_q;
    bus.MemAddr = pc;
    bus.CurPC   = pc;
    bus.DateOut = dout;
  end

  // Datapath: PC, captured word, wait counter, error pulse
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc    <= RESET_PC;
      dout  <= '0;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      // PC loads are honoured only in IDLE. While busy they are dropped silently.
      if (state == IDLE && bus.PCWre) pc <= bus.NextPC;
      else if (state == WRITE)        pc <= pc + 32'd4;

      if (got_ack) dout <= bus.MemData;

      // The counter idles at zero outside MEM, so it is clear on every MEM entry.
      if (state != MEM)     wcnt <= '0;
      else if (!bus.MemAck) wcnt <= wcnt + 1'b1;

      err_q <= bad_fetch | timeout;
    end
  end
endmodule

// File: tb/tb_ins_fetch.sv
module tb_ins_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 15;

  logic CLK;
  logic Reset;
  ins_fetch_if bus();

  ins_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference state: the architectural PC and last captured word.
  logic [31:0] exp_pc;
  logic [31:0] exp_dout;

  // Runs one fetch. The caller is just past a falling edge. The outcome is
  // predicted from the rules:
  //   misaligned address -> Err, no MemReq
  //   ack after delay wait cycles, with delay < TO -> success, PC+4
  //   otherwise -> timeout after TO MemReq cycles
  // When noise is set, ignored PCWre/FetchReq/MemData activity is injected while busy.
  task automatic run_fetch(input string tag, input bit use_wre, input logic [31:0] na,
                           input logic [31:0] data, input int delay, input bit noise);
    logic [31:0] fa;
    bit acked;
    fa = use_wre ? na : exp_pc;
    bus.FetchReq = 1'b1; bus.PCWre = use_wre; bus.NextPC = na;
    @(negedge CLK);
    bus.FetchReq = 1'b0; bus.PCWre = 1'b0;
    if (fa[1:0] != 2'b00) begin
      checks++; if (bus.Err !== 1'b1) begin failures++; $display("FAIL %s mis_err got=%b exp=1", tag, bus.Err); end
      checks++; if (bus.MemReq !== 1'b0) begin failures++; $display("FAIL %s mis_memreq got=%b exp=0", tag, bus.MemReq); end
      checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL %s mis_busy got=%b exp=0", tag, bus.Busy); end
      @(negedge CLK);
      checks++; if (bus.Err !== 1'b0) begin failures++; $display("FAIL %s mis_err_pulse got=%b exp=0", tag, bus.Err); end
      checks++; if (bus.CurPC !== exp_pc) begin failures++; $display("FAIL %s mis_pc got=%h exp=%h", tag, bus.CurPC, exp_pc); end
      return;
    end
    exp_pc = fa;
    acked = 0;
    for (int k = 0; k < TO; k++) begin
      checks++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== fa) begin
        failures++; $display("FAIL %s memreq k=%0d got=%b/%h exp=1/%h", tag, k, bus.MemReq, bus.MemAddr, fa);
      end
      checks++; if (bus.IRWre !== 1'b0 || bus.Err !== 1'b0) begin
        failures++; $display("FAIL %s mem_quiet k=%0d got irwre=%b err=%b exp=0/0", tag, k, bus.IRWre, bus.Err);
      end
      if (noise && k < delay) begin
        bus.PCWre = 1'b1; bus.NextPC = $urandom; bus.FetchReq = 1'b1; bus.MemData = $urandom;
      end
      if (k == delay) begin bus.MemAck = 1'b1; bus.MemData = data; end
      @(negedge CLK);
      bus.PCWre = 1'b0; bus.FetchReq = 1'b0; bus.MemAck = 1'b0;
      if (k == delay) begin acked = 1; break; end
    end
    if (acked) begin
      checks++; if (bus.IRWre !== 1'b1 || bus.Done !== 1'b1) begin
        failures++; $display("FAIL %s write got irwre=%b done=%b exp=1/1", tag, bus.IRWre, bus.Done);
      end
      checks++; if (bus.DateOut !== data) begin failures++; $display("FAIL %s dateout got=%h exp=%h", tag, bus.DateOut, data); end
      checks++; if (bus.CurPC !== fa) begin failures++; $display("FAIL %s pc_in_write got=%h exp=%h", tag, bus.CurPC, fa); end
      exp_dout = data;
      exp_pc   = fa + 32'd4;
      @(negedge CLK);
      checks++; if (bus.IRWre !== 1'b0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Err !== 1'b0) begin
        failures++; $display("FAIL %s post_write got irwre=%b done=%b busy=%b err=%b exp=0", tag, bus.IRWre, bus.Done, bus.Busy, bus.Err);
      end
      checks++; if (bus.CurPC !== exp_pc) begin failures++; $display("FAIL %s pc_adv got=%h exp=%h", tag, bus.CurPC, exp_pc); end
    end else begin
      checks++; if (bus.Err !== 1'b1) begin failures++; $display("FAIL %s to_err got=%b exp=1", tag, bus.Err); end
      checks++; if (bus.MemReq !== 1'b0 || bus.Busy !== 1'b0 || bus.IRWre !== 1'b0) begin
        failures++; $display("FAIL %s to_idle got memreq=%b busy=%b irwre=%b exp=0", tag, bus.MemReq, bus.Busy, bus.IRWre);
      end
      checks++; if (bus.CurPC !== fa || bus.DateOut !== exp_dout) begin
        failures++; $display("FAIL %s to_hold got=%h/%h exp=%h/%h", tag, bus.CurPC, bus.DateOut, fa, exp_dout);
      end
      @(negedge CLK);
      checks++; if (bus.Err !== 1'b0) begin failures++; $display("FAIL %s to_err_pulse got=%b exp=0", tag, bus.Err); end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #1;
    checks++; if (bus.Busy !== 1'b0 || bus.MemReq !== 1'b0 || bus.IRWre !== 1'b0 || bus.Done !== 1'b0 || bus.Err !== 1'b0) begin
      failures++; $display("FAIL reset_ctl got busy=%b memreq=%b irwre=%b done=%b err=%b exp=0", bus.Busy, bus.MemReq, bus.IRWre, bus.Done, bus.Err);
    end
    checks++; if (bus.CurPC !== RST_PC || bus.MemAddr !== RST_PC) begin
      failures++; $display("FAIL reset_pc got=%h/%h exp=%h", bus.CurPC, bus.MemAddr, RST_PC);
    end
    checks++; if (bus.DateOut !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.DateOut); end
    exp_pc = RST_PC; exp_dout = 32'h0;
  endtask

  task automatic test_basic();
    // Reset is released on the same falling edge as FetchReq, so the first rising edge starts the fetch.
    @(negedge CLK);
    Reset = 1'b1;
    run_fetch("basic", 1'b0, 32'h0, 32'h8C01_0004, 0, 1'b0);
    checks++; if (bus.CurPC !== 32'h4) begin failures++; $display("FAIL basic_curpc got=%h exp=4", bus.CurPC); end
  endtask

  task automatic test_wait();
    run_fetch("wait5", 1'b1, 32'h40, 32'h1234_5678, 5, 1'b0);
    checks++; if (bus.CurPC !== 32'h44) begin failures++; $display("FAIL wait5_curpc got=%h exp=44", bus.CurPC); end
  endtask

  task automatic test_timeout();
    run_fetch("timeout", 1'b1, 32'h80, 32'hDEAD_BEEF, TO, 1'b0);
    run_fetch("last_ack", 1'b1, 32'h84, 32'hCAFE_F00D, TO - 1, 1'b0);
  endtask

  task automatic test_misalign_wrap();
    bus.PCWre = 1'b1; bus.NextPC = 32'h42;
    @(negedge CLK);
    bus.PCWre = 1'b0;
    exp_pc = 32'h42;
    checks++; if (bus.CurPC !== 32'h42) begin failures++; $display("FAIL load_pc got=%h exp=42", bus.CurPC); end
    run_fetch("misalign", 1'b0, 32'h0, 32'h1111_1111, 0, 1'b0);
    run_fetch("wrap", 1'b1, 32'hFFFF_FFFC, 32'h2222_2222, 2, 1'b0);
    checks++; if (bus.CurPC !== 32'h0) begin failures++; $display("FAIL wrap_curpc got=%h exp=0", bus.CurPC); end
  endtask

  task automatic test_reset_mid();
    bus.FetchReq = 1'b1; bus.PCWre = 1'b1; bus.NextPC = 32'h100;
    @(negedge CLK);
    bus.FetchReq = 1'b0; bus.PCWre = 1'b0;
    checks++; if (bus.MemReq !== 1'b1) begin failures++; $display("FAIL rmid_memreq got=%b exp=1", bus.MemReq); end
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    checks++; if (bus.MemReq !== 1'b0 || bus.Busy !== 1'b0) begin
      failures++; $display("FAIL rmid_async got memreq=%b busy=%b exp=0", bus.MemReq, bus.Busy);
    end
    checks++; if (bus.CurPC !== RST_PC) begin failures++; $display("FAIL rmid_pc got=%h exp=%h", bus.CurPC, RST_PC); end
    exp_pc = RST_PC; exp_dout = 32'h0;
    @(negedge CLK);
    Reset = 1'b1; bus.MemAck = 1'b1; bus.MemData = 32'h5555_AAAA;
    @(negedge CLK);
    bus.MemAck = 1'b0;
    checks++; if (bus.IRWre !== 1'b0 || bus.DateOut !== 32'h0 || bus.Busy !== 1'b0) begin
      failures++; $display("FAIL rmid_late_ack got irwre=%b dout=%h busy=%b exp=0/0/0", bus.IRWre, bus.DateOut, bus.Busy);
    end
    @(negedge CLK);
    checks++; if (bus.CurPC !== RST_PC) begin failures++; $display("FAIL rmid_pc_after got=%h exp=%h", bus.CurPC, RST_PC); end
  endtask

  task automatic test_busy_ignore();
    run_fetch("busy_noise", 1'b1, 32'h200, 32'h0BAD_CAFE, 4, 1'b1);
    bus.MemAck = 1'b1; bus.MemData = 32'hFFFF_0000;
    @(negedge CLK);
    bus.MemAck = 1'b0;
    checks++; if (bus.DateOut !== exp_dout || bus.CurPC !== exp_pc) begin
      failures++; $display("FAIL stray_ack got=%h/%h exp=%h/%h", bus.DateOut, bus.CurPC, exp_dout, exp_pc);
    end
    checks++; if (bus.Busy !== 1'b0 || bus.Err !== 1'b0 || bus.MemReq !== 1'b0) begin
      failures++; $display("FAIL stray_ctl got busy=%b err=%b memreq=%b exp=0", bus.Busy, bus.Err, bus.MemReq);
    end
  endtask

  task automatic test_back_to_back();
    // With FetchReq and MemAck held high, the expected sequence is MEM, WRITE, IDLE, MEM, WRITE, IDLE.
    bus.PCWre = 1'b1; bus.NextPC = 32'h300; bus.FetchReq = 1'b1; bus.MemAck = 1'b1; bus.MemData = 32'hA0A0_0001;
    @(negedge CLK);
    bus.PCWre = 1'b0;
    checks++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h300) begin failures++; $display("FAIL b2b_mem1 got=%b/%h exp=1/300", bus.MemReq, bus.MemAddr); end
    @(negedge CLK);
    checks++; if (bus.IRWre !== 1'b1 || bus.DateOut !== 32'hA0A0_0001) begin failures++; $display("FAIL b2b_wr1 got=%b/%h exp=1/a0a00001", bus.IRWre, bus.DateOut); end
    @(negedge CLK);
    bus.MemData = 32'hA0A0_0002;
    checks++; if (bus.Busy !== 1'b0 || bus.CurPC !== 32'h304) begin failures++; $display("FAIL b2b_idle got=%b/%h exp=0/304", bus.Busy, bus.CurPC); end
    @(negedge CLK);
    checks++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h304) begin failures++; $display("FAIL b2b_mem2 got=%b/%h exp=1/304", bus.MemReq, bus.MemAddr); end
    @(negedge CLK);
    bus.FetchReq = 1'b0; bus.MemAck = 1'b0;
    checks++; if (bus.IRWre !== 1'b1 || bus.DateOut !== 32'hA0A0_0002) begin failures++; $display("FAIL b2b_wr2 got=%b/%h exp=1/a0a00002", bus.IRWre, bus.DateOut); end
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (bus.Busy !== 1'b0 || bus.CurPC !== 32'h308) begin failures++; $display("FAIL b2b_end got=%b/%h exp=0/308", bus.Busy, bus.CurPC); end
    exp_pc = 32'h308; exp_dout = 32'hA0A0_0002;
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        // Load a misaligned PC first, then request a fetch from it.
        r[1:0] = 2'($urandom_range(1, 3));
        bus.PCWre = 1'b1; bus.NextPC = r;
        @(negedge CLK);
        bus.PCWre = 1'b0;
        exp_pc = r;
        run_fetch("rnd_mis", 1'b0, 32'h0, $urandom, 0, 1'b0);
      end else if (exp_pc[1:0] == 2'b00 && $urandom_range(0, 1) == 1) begin
        run_fetch("rnd_seq", 1'b0, 32'h0, $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
      end else begin
        r[1:0] = 2'b00;
        run_fetch("rnd_load", 1'b1, r, $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    bus.FetchReq = 1'b0; bus.PCWre = 1'b0; bus.NextPC = 32'h0;
    bus.MemAck = 1'b0; bus.MemData = 32'h0;
    exp_pc = RST_PC; exp_dout = 32'h0;
    test_reset();
    test_basic();
    test_wait();
    test_timeout();
    test_misalign_wrap();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
